chroma_key_sequencer: RTL and testbench

- Frame-level controller for the green-screen compositing datapath.
- On a start pulse, walks every pixel address of a frame through two synchronous-read pixel buffers: green-screen (gs) and background (bk).
- Applies the green key and emits the composited ARGB pixel stream with valid/ready backpressure; pulses done after the last pixel is accepted.
- Sits between the frame-buffer RAMs and the display/output writer.

---
 rtl/chroma_pkg.sv | 31 +++
 rtl/chroma_key_fifo2.sv | 53 +++++
 rtl/chroma_key_sequencer.sv | 168 ++++++++++++++++
 tb/tb_chroma_key_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chroma_pkg.sv
// Shared definitions for the chroma-key compositing slice: ARGB layout,
// default key thresholds and the frame sequencer state encoding.
package chroma_pkg;

  localparam int PIX_W = 32;

  // ARGB field offsets within a 32-bit pixel
  localparam int A_LSB = 24;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // Default key thresholds
  localparam int G_MIN_DEF  = 200;
  localparam int RB_MAX_DEF = 200;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/chroma_key_fifo2.sv
// Two-entry fall-through output buffer. When empty, an incoming entry is
// presented on the same cycle it is pushed; if the consumer takes it then,
// it is never stored. The head entry is held stable until popped.
module chroma_key_fifo2 #(
  parameter int DATA_W = 43
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;
  logic              empty;
  logic              take;
  logic              wr;
  logic              rd;

  assign empty     = (cnt == 2'd0);
  assign out_valid = !empty || push;
  assign out_data  = empty ? push_data : mem[rd_ptr];
  assign take      = out_valid && pop;
  // An entry consumed on arrival bypasses storage
  assign wr        = push && !(empty && take);
  assign rd        = take && !empty;
  assign count     = cnt;

  // Pointer and occupancy control
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr) wr_ptr <= ~wr_ptr;
      if (rd) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, wr} - {1'b0, rd};
    end
  end

  // Entry storage, data only
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/chroma_key_sequencer.sv
// Frame sequencer for green-screen compositing. On start it reads every
// pixel address from the gs and bk buffers (1-cycle read latency), keys the
// gs pixel, and streams the composited ARGB pixel with valid/ready.
// Optional: define CHROMA_KEY_STATS_EN to add the key_count output.
module chroma_key_sequencer
  import chroma_pkg::*;
#(
  parameter int NUM_PIXELS = 750,
  parameter int ADDR_W     = 10,
  parameter int G_MIN      = G_MIN_DEF,
  parameter int RB_MAX     = RB_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       gs_rdata,
  input  logic [31:0]       bk_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pixel,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_keyed,
  output logic              out_last
`ifdef CHROMA_KEY_STATS_EN
  ,
  output logic [ADDR_W:0]   key_count
`endif
);

  localparam int               ENT_W     = PIX_W + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [7:0]        G_MIN8    = 8'(G_MIN);
  localparam logic [7:0]        RB_MAX8   = 8'(RB_MAX);

  state_t            state;
  logic              vld_p1;
  logic [ADDR_W-1:0] idx_p1;
  pixel_t            gs_px;
  pixel_t            bk_px;
  pixel_t            comp_px;
  logic              key_p1;
  logic [ENT_W-1:0]  push_data;
  logic [ENT_W-1:0]  fifo_head;
  logic              fifo_valid;
  logic [1:0]        fifo_cnt;
  logic              hs;
  logic              pop_fifo;
  logic [1:0]        occ_after;
  pixel_t            o_pix;
  logic [ADDR_W-1:0] o_idx;
  logic              o_key;

  function automatic logic is_keyed(input pixel_t p);
    return (p.g >= G_MIN8) && (p.r < RB_MAX8) && (p.b < RB_MAX8);
  endfunction

  // Keyed pixels take RGB from the background; alpha always stays from gs
  function automatic pixel_t composite(input pixel_t gs, input pixel_t bk, input logic k);
    pixel_t res;
    if (k) begin
      res   = bk;
      res.a = gs.a;
    end else begin
      res = gs;
    end
    return res;
  endfunction

  // Stage p1: read data returned from both buffers
  assign gs_px     = pixel_t'(gs_rdata);
  assign bk_px     = pixel_t'(bk_rdata);
  assign key_p1    = is_keyed(gs_px);
  assign comp_px   = composite(gs_px, bk_px, key_p1);
  assign push_data = {comp_px, idx_p1, key_p1};

  chroma_key_fifo2 #(
    .DATA_W(ENT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (vld_p1),
    .push_data(push_data),
    .pop      (out_ready),
    .out_valid(fifo_valid),
    .out_data (fifo_head),
    .count    (fifo_cnt)
  );

  // Output stage: fields forced to zero whenever nothing is presented
  assign {o_pix, o_idx, o_key} = fifo_head;
  assign out_valid = fifo_valid;
  assign out_pixel = fifo_valid ? o_pix : 32'd0;
  assign out_index = fifo_valid ? o_idx : '0;
  assign out_keyed = fifo_valid && o_key;
  assign out_last  = fifo_valid && (o_idx == LAST_ADDR);
  assign hs        = out_valid && out_ready;

  // Read admission: stored entries left after this cycle's pop plus the read
  // already in flight must leave room for one more
  assign pop_fifo  = hs && (fifo_cnt != 2'd0);
  assign occ_after = fifo_cnt - {1'b0, pop_fifo};
  assign rd_en     = (state == RUN) && ((occ_after + {1'b0, vld_p1}) < 2'd2);

  // Stage p0 -> p1: track the outstanding read (control)
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= rd_en;
  end

  // Stage p0 -> p1: index travelling with the read (data)
  always_ff @(posedge clk) begin
    if (rd_en) idx_p1 <= rd_addr;
  end

  // Frame FSM with registered busy/done and address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            rd_addr <= '0;
          end
        end
        RUN: begin
          if (rd_en) begin
            if (rd_addr == LAST_ADDR) state <= DRAIN;
            else                      rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          // The last-pixel handshake leaves the buffer and read pipe empty
          if (hs && out_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          rd_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHROMA_KEY_STATS_EN
  // Keyed-pixel counter over accepted beats of the current frame
  always_ff @(posedge clk) begin
    if (rst)                            key_count <= '0;
    else if (state == IDLE && start)    key_count <= '0;
    else if (hs && out_keyed)           key_count <= key_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_chroma_key_sequencer.sv
// Scoreboard bench for chroma_key_sequencer: a frame-level model fills the
// expected queue, a negedge monitor checks every accepted beat.
module tb_chroma_key_sequencer;

  localparam int NP = 750;
  localparam int AW = 10;

  typedef struct {
    logic [31:0] pix;
    int          idx;
    bit          key;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   gs_rdata = 32'd0;
  logic [31:0]   bk_rdata = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pixel;
  logic [AW-1:0] out_index;
  logic          out_keyed, out_last;
`ifdef CHROMA_KEY_STATS_EN
  logic [AW:0]   key_count;
`endif

  logic [31:0] gs_mem [NP];
  logic [31:0] bk_mem [NP];
  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          rd_cnt = 0, hs_cnt = 0, done_cnt = 0, max_out = 0;
  int          ready_mode = 0;
  int          kexp = 0;
  bit          stall_prev = 0;
  logic [31:0] hold_pix;
  logic [AW-1:0] hold_idx;
  logic        hold_key;

  chroma_key_sequencer #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .gs_rdata(gs_rdata), .bk_rdata(bk_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_index(out_index), .out_keyed(out_keyed), .out_last(out_last)
`ifdef CHROMA_KEY_STATS_EN
    , .key_count(key_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read pixel buffers
  always @(posedge clk) begin
    if (rd_en) begin
      gs_rdata <= gs_mem[rd_addr];
      bk_rdata <= bk_mem[rd_addr];
    end
  end

  // Consumer readiness
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(99) < 30);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Keying rule stated on byte fields of the gs pixel
  function automatic bit model_key(input logic [31:0] p);
    int r, g, b;
    r = int'((p >> 16) & 32'hFF);
    g = int'((p >> 8) & 32'hFF);
    b = int'(p & 32'hFF);
    return (g >= 200) && (r < 200) && (b < 200);
  endfunction

  // Monitor: beat scoreboard, stall stability, outstanding reads, done pulses
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 0;
      rd_cnt = 0;
      hs_cnt = 0;
    end else begin
      if (stall_prev) begin
        tests++;
        if (!out_valid || out_pixel !== hold_pix || out_index !== hold_idx || out_keyed !== hold_key) begin
          fails++;
          $display("FAIL stall_hold: got v=%0b pix=%0h idx=%0d required pix=%0h idx=%0d",
                   out_valid, out_pixel, out_index, hold_pix, hold_idx);
        end
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat_unexpected: got idx=%0d pix=%0h required none", out_index, out_pixel);
        end else begin
          e = exp_q.pop_front();
          if (out_pixel !== e.pix || int'(out_index) != e.idx || out_keyed !== e.key ||
              out_last !== (e.idx == NP - 1)) begin
            fails++;
            $display("FAIL beat: got idx=%0d pix=%0h key=%0b last=%0b required idx=%0d pix=%0h key=%0b",
                     out_index, out_pixel, out_keyed, out_last, e.idx, e.pix, e.key);
          end
        end
      end
      if (rd_en) rd_cnt++;
      if (rd_cnt - hs_cnt > max_out) max_out = rd_cnt - hs_cnt;
      if (done) done_cnt++;
      stall_prev = out_valid && !out_ready;
      hold_pix = out_pixel;
      hold_idx = out_index;
      hold_key = out_keyed;
    end
  end

  // Pattern 0: constant green screen; 1: threshold mix; 2: alpha retention
  task automatic fill(input int pat);
    logic [31:0] edges [5];
    edges[0] = 32'hFF00C8C7;
    edges[1] = 32'hFF00C7C7;
    edges[2] = 32'hFFC8FF00;
    edges[3] = 32'h3A00FF00;
    edges[4] = 32'hFF10F010;
    for (int i = 0; i < NP; i++) begin
      case (pat)
        0: begin gs_mem[i] = 32'hFF10F010; bk_mem[i] = 32'(i); end
        1: begin
          gs_mem[i] = ($urandom_range(3) == 0) ? $urandom : edges[$urandom_range(4)];
          bk_mem[i] = $urandom;
        end
        default: begin gs_mem[i] = 32'h3A00FF00; bk_mem[i] = 32'h80112233; end
      endcase
    end
  endtask

  task automatic push_expected();
    exp_t e;
    kexp = 0;
    for (int i = 0; i < NP; i++) begin
      e.key = model_key(gs_mem[i]);
      e.pix = e.key ? ((gs_mem[i] & 32'hFF000000) | (bk_mem[i] & 32'h00FFFFFF)) : gs_mem[i];
      e.idx = i;
      if (e.key) kexp++;
      exp_q.push_back(e);
    end
  endtask

  // mode 0: always ready; 1: random 30% ready; 2: stalled at first then ready
  task automatic run_frame(input int mode, input bit poke, input string tag);
    int cyc, base_done, base_rd;
    push_expected();
    base_done = done_cnt;
    base_rd = rd_cnt;
    max_out = 0;
    ready_mode = (mode == 2) ? 2 : mode;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1;
    chk({tag, "_busy_k1"}, 32'(busy), 32'd1);
    chk({tag, "_rden_k1"}, 32'(rd_en), 32'd1);
    chk({tag, "_addr_k1"}, 32'(rd_addr), 32'd0);
    @(posedge clk); #1; cyc = 2;
    chk({tag, "_valid_k2"}, 32'(out_valid), 32'd1);
    chk({tag, "_index_k2"}, 32'(out_index), 32'd0);
    while (!done && cyc < 8000) begin
      if (mode == 2 && cyc == 12) begin
        chk({tag, "_stall_reads"}, 32'(rd_cnt - base_rd), 32'd2);
        chk({tag, "_stall_index"}, 32'(out_index), 32'd0);
        ready_mode = 0;
      end
      start = poke && busy && ($urandom_range(7) == 0);
      @(posedge clk); #1; cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    if (mode == 0) chk({tag, "_latency"}, 32'(cyc), 32'd752);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_outstanding_le2"}, 32'(max_out <= 2), 32'd1);
`ifdef CHROMA_KEY_STATS_EN
    chk({tag, "_key_count"}, 32'(key_count), 32'(kexp));
`endif
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk({tag, "_start_in_done_ignored"}, 32'(busy), 32'd0);
    chk({tag, "_single_done"}, 32'(done_cnt - base_done), 32'd1);
    exp_q.delete();
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_pixel"}, out_pixel, 32'd0);
    chk({tag, "_out_index"}, 32'(out_index), 32'd0);
    chk({tag, "_out_keyed_last"}, 32'({out_keyed, out_last}), 32'd0);
  endtask

  initial begin
    int base_hs, base_done, w;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    fill(0);
    run_frame(0, 1'b0, "green");
    fill(1);
    run_frame(1, 1'b1, "thresh");
    fill(2);
    run_frame(2, 1'b0, "alpha");

    // Reset mid-frame at beat 400
    fill(1);
    push_expected();
    ready_mode = 0;
    base_hs = hs_cnt;
    base_done = done_cnt;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    w = 0;
    while (hs_cnt - base_hs < 400 && w < 2000) begin
      @(posedge clk); #1; w++;
    end
    chk("abort_reached_400", 32'(hs_cnt - base_hs >= 400), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_zero("abort");
    exp_q.delete();
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    fill(1);
    run_frame(1, 1'b1, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
